// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_arb_pkg
//  Purpose  : Shared types and constants for the SPI request arbiter:
//             FSM state encoding, frame length, command flag values and the
//             frame-length helper.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // One read/write flag bit followed by 8 data bits
    localparam int   FRAME_BITS = 9;

    localparam logic CMD_READ   = 1'b1;
    localparam logic CMD_WRITE  = 1'b0;

    // clk cycles that CS stays low for one frame (setup + 9 bits + hold)
    function automatic int frame_cycles(input int div);
        return 20 * div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rr_arbiter
//  Purpose  : Picks one requester out of a request vector. Round-robin by
//             default: the pointer names the highest-priority index and moves
//             to winner+1 when the winner is accepted.
//             Build option SPI_ARB_FIXED_PRIO_EN: fixed priority, lowest index
//             wins, and the pointer register disappears.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic [NUM_REQ-1:0] w_grant;

`ifndef SPI_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   r_ptr;
`endif

    // Scan candidates in priority order; the first active request wins
    always_comb begin
        w_cand  = '0;
        w_idx   = '0;
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
            w_cand = IDX_W'(i);
`else
            w_cand = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
`endif
            if (!w_any && req[w_cand]) begin
                w_any = 1'b1;
                w_idx = w_cand;
            end
        end
        if (w_any) begin
            w_grant[w_idx] = 1'b1;
        end
    end

`ifndef SPI_ARB_FIXED_PRIO_EN
    // Rotate priority so the requester after the accepted winner goes first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (accept) begin
            r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end
`endif

    assign grant     = w_grant;
    assign grant_idx = w_idx;
    assign any       = w_any;

endmodule
`default_nettype wire

// File: rtl/spi_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_req_arbiter
//  Purpose  : Shares one SPI bus between NUM_REQ requesters. Each frame is a
//             read/write flag bit then 8 data bits LSB-first; read frames
//             capture MISO and return the byte on rdata.
//             Build option SPI_ARB_FIXED_PRIO_EN selects fixed priority
//             (lowest index wins) instead of round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DIV     = 9,
    parameter int GAP     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   rw,
    input  logic [NUM_REQ*8-1:0] wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rdata,
    output logic                 busy,
    input  logic                 miso,
    output logic                 cs,
    output logic                 sclk,
    output logic                 mosi
);

    localparam int              c_idx_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int              c_cnt_max  = (DIV > GAP) ? DIV : GAP;
    localparam int              c_cnt_w    = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(GAP - 1);
    localparam logic [3:0]      c_last_bit = 4'(FRAME_BITS - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_bit;
    logic                 r_rw;
    logic [7:0]           r_wdata;
    logic [7:0]           r_shreg;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [7:0]           r_rdata;
    logic                 r_busy;
    logic                 r_cs;
    logic                 r_sclk;
    logic                 r_mosi;

    logic [NUM_REQ-1:0]   w_win_onehot;
    logic [c_idx_w-1:0]   w_win_idx;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_win_rw;
    logic [7:0]           w_win_wdata;

    assign w_accept = (r_state == ST_IDLE) && w_any;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .accept    (w_accept),
        .grant     (w_win_onehot),
        .grant_idx (w_win_idx),
        .any       (w_any)
    );

    // Route the winning requester's command flag and write byte
    always_comb begin
        w_win_rw    = 1'b0;
        w_win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == c_idx_w'(i)) begin
                w_win_rw    = rw[i];
                w_win_wdata = wdata[i*8 +: 8];
            end
        end
    end

    // Frame sequencer: grant, SCLK generation, bit shifting and completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_rw    <= CMD_WRITE;
            r_wdata <= '0;
            r_shreg <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_rw    <= w_win_rw;
                        r_wdata <= w_win_wdata;
                        r_gnt   <= w_win_onehot;
                        r_busy  <= 1'b1;
                        r_cs    <= 1'b0;
                        r_mosi  <= w_win_rw;
                        r_cnt   <= '0;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_sclk  <= 1'b0;
                        r_mosi  <= r_rw;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt <= '0;
                        if (!r_sclk) begin
                            // Rising edge: read frames sample data bits 1..8
                            r_sclk <= 1'b1;
                            if (r_rw == CMD_READ && r_bit != 4'd0) begin
                                r_shreg <= {miso, r_shreg[7:1]};
                            end
                        end else if (r_bit == c_last_bit) begin
                            r_state <= ST_HOLD;
                        end else begin
                            // Falling edge: present bit k+1 (wdata[k])
                            r_bit  <= r_bit + 4'd1;
                            r_sclk <= 1'b0;
                            r_mosi <= (r_rw == CMD_READ) ? 1'b0 : r_wdata[r_bit[2:0]];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt   <= '0;
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_gnt   <= '0;
                        r_done  <= r_gnt;
                        if (r_rw == CMD_READ) begin
                            r_rdata <= r_shreg;
                        end
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign busy  = r_busy;
    assign cs    = r_cs;
    assign sclk  = r_sclk;
    assign mosi  = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_req_arbiter
//  Purpose  : Self-checking bench for spi_req_arbiter (NUM_REQ=4, DIV=2,
//             GAP=4). A frame-level timing model predicts every output each
//             cycle; an SPI slave model supplies MISO and collects MOSI;
//             directed scenarios pin the model with literal expectations,
//             followed by randomized request traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_req_arbiter;
    import spi_arb_pkg::*;

    localparam int NR  = 4;
    localparam int DIV = 2;
    localparam int GAP = 4;
    localparam int FR  = frame_cycles(DIV);

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic [NR-1:0]   req     = '0;
    logic [NR-1:0]   rw      = '0;
    logic [NR*8-1:0] wdata   = '0;
    logic            miso    = 1'b0;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic [7:0]      rdata;
    logic            busy;
    logic            cs;
    logic            sclk;
    logic            mosi;

    always #5 clk = ~clk;

    spi_req_arbiter #(
        .NUM_REQ (NR),
        .DIV     (DIV),
        .GAP     (GAP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .rw      (rw),
        .wdata   (wdata),
        .gnt     (gnt),
        .done    (done),
        .rdata   (rdata),
        .busy    (busy),
        .miso    (miso),
        .cs      (cs),
        .sclk    (sclk),
        .mosi    (mosi)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit         m_active = 1'b0;
    int         m_t      = 0;     // cycles since the grant edge
    int         m_idx    = 0;
    int         m_ptr    = 0;
    logic       m_rw     = 1'b0;
    logic [7:0] m_wdata  = '0;
    logic [7:0] m_rbyte  = '0;
    logic [7:0] m_rdata  = '0;
    logic [7:0] next_rbyte = '0;

    function automatic logic bitval(input int k);
        if (k == 0) return m_rw;
        if (m_rw)   return 1'b0;
        return m_wdata[k-1];
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int w;
        int j;
        if (!reset_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_ptr    = 0;
            m_rdata  = '0;
        end else if (m_active) begin
            m_t = m_t + 1;
            if (m_t == FR && m_rw) m_rdata = m_rbyte;
            if (m_t == FR + GAP)   m_active = 1'b0;
        end else begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
                j = k;
`else
                j = (m_ptr + k) % NR;
`endif
                if (w < 0 && req[j]) w = j;
            end
            if (w >= 0) begin
                m_active = 1'b1;
                m_t      = 0;
                m_idx    = w;
                m_rw     = rw[w];
                m_wdata  = wdata[w*8 +: 8];
                m_rbyte  = next_rbyte;
                m_ptr    = (w + 1) % NR;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin : compare
        logic          e_cs, e_sclk, e_mosi, e_busy;
        logic [NR-1:0] e_gnt, e_done;
        int            u;
        e_cs = 1'b1; e_sclk = 1'b1; e_mosi = 1'b0; e_busy = 1'b0;
        e_gnt = '0; e_done = '0; u = 0;
        if (m_active) begin
            e_busy = 1'b1;
            if (m_t < FR) begin
                e_cs = 1'b0;
                e_gnt[m_idx] = 1'b1;
                if (m_t < DIV) begin
                    e_mosi = bitval(0);
                end else if (m_t >= FR - DIV) begin
                    e_mosi = bitval(FRAME_BITS - 1);
                end else begin
                    u      = m_t - DIV;
                    e_sclk = (u % (2*DIV)) >= DIV;
                    e_mosi = bitval(u / (2*DIV));
                end
            end else if (m_t == FR) begin
                e_done[m_idx] = 1'b1;
            end
        end
        check("cs",    cs,    e_cs);
        check("sclk",  sclk,  e_sclk);
        check("mosi",  mosi,  e_mosi);
        check("busy",  busy,  e_busy);
        check("gnt",   gnt,   e_gnt);
        check("done",  done,  e_done);
        check("rdata", rdata, m_rdata);
    end

    // ---------------- monitors ----------------
    logic [NR-1:0] prev_gnt = '0;
    int grant_log[$];
    int done_cnt[NR] = '{default: 0};
    int lo_run = 0, hi_run = 0, last_lo = 0, last_hi = 0;

    always @(negedge clk) begin : monitor
        if (gnt != '0 && prev_gnt == '0)
            for (int i = 0; i < NR; i++) if (gnt[i]) grant_log.push_back(i);
        prev_gnt = gnt;
        for (int i = 0; i < NR; i++) if (done[i]) done_cnt[i]++;
        if (!cs) begin
            if (hi_run != 0) begin last_hi = hi_run; hi_run = 0; end
            lo_run++;
        end else begin
            if (lo_run != 0) begin last_lo = lo_run; lo_run = 0; end
            hi_run++;
        end
    end

    // ---------------- SPI slave model ----------------
    int         fall_cnt = 0;
    int         fbit_n   = 0;
    logic [8:0] fbits    = '0;

    always @(negedge cs) begin
        fall_cnt = 0;
        fbit_n   = 0;
        fbits    = '0;
    end

    always @(negedge sclk) begin
        if (!cs && reset_n) begin
            if (fall_cnt >= 1 && fall_cnt <= 8) miso = m_rbyte[fall_cnt-1];
            fall_cnt++;
        end
    end

    always @(posedge sclk) begin
        if (!cs && reset_n) begin
            if (fbit_n < 9) fbits[fbit_n] = mosi;
            fbit_n++;
        end
    end

    always @(posedge cs) begin : frame_end
        logic [8:0] e_bits;
        if (reset_n) begin
            for (int k = 0; k < 9; k++) e_bits[k] = bitval(k);
            check("frame_bit_count", fbit_n, 9);
            check("frame_mosi_bits", fbits, e_bits);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int i, input string name);
        int c = 0;
        while (!gnt[i] && c < 200) begin tick(); c++; end
        check(name, gnt[i], 1'b1);
    endtask

    task automatic wait_done(input int i, input string name);
        int c = 0;
        while (!done[i] && c < 200) begin tick(); c++; end
        check(name, done[i], 1'b1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int exp_rr[3] = '{0, 1, 3};
        int d0;
        int c;

        // Reset state
        repeat (3) tick();
        check("rst_cs",    cs,    1'b1);
        check("rst_sclk",  sclk,  1'b1);
        check("rst_mosi",  mosi,  1'b0);
        check("rst_gnt",   gnt,   4'b0000);
        check("rst_done",  done,  4'b0000);
        check("rst_rdata", rdata, 8'h00);
        check("rst_busy",  busy,  1'b0);
        reset_n = 1'b1;
        tick();

        // Round-robin from pointer 0: 0,1,3
        rw    = '0;
        wdata = 32'h1122_3344;
        req   = 4'b1011;
        c = 0;
        while (req != '0 && c < 400) begin
            tick(); c++;
            for (int i = 0; i < NR; i++) if (done[i]) req[i] = 1'b0;
        end
        check("rr_count", grant_log.size(), 3);
        for (int k = 0; k < 3 && k < grant_log.size(); k++) check("rr_order", grant_log[k], exp_rr[k]);
        check("rr_gap_min", (last_hi >= GAP), 1'b1);
        grant_log.delete();

        // Read from requester 2; slave returns 1,1,0,0,1,0,1,0 -> 8'h53
        next_rbyte = 8'h53;
        rw[2]  = 1'b1;
        req[2] = 1'b1;
        wait_gnt(2, "rd_gnt_wait");
        check("rd_gnt", gnt, 4'b0100);
        wait_done(2, "rd_done_wait");
        req[2] = 1'b0;
        check("rd_done",  done,  4'b0100);
        check("rd_rdata", rdata, 8'h53);
        check("rd_bits",  fbits, 9'b000000001);
        check("rd_cs_low", last_lo, 40);

        // Write 8'hA5 from requester 1
        d0 = done_cnt[1];
        rw[1] = 1'b0;
        wdata[15:8] = 8'hA5;
        req[1] = 1'b1;
        wait_gnt(1, "wr_gnt_wait");
        check("wr_gnt", gnt, 4'b0010);
        wait_done(1, "wr_done_wait");
        req[1] = 1'b0;
        check("wr_bits",   fbits, 9'b101001010);
        check("wr_cs_low", last_lo, 40);
        repeat (8) tick();
        check("wr_done_once", done_cnt[1], d0 + 1);
        check("wr_rdata_kept", rdata, 8'h53);

        // Requester 0 drops req (and scribbles wdata) during bit 3
        rw[0] = 1'b0;
        wdata[7:0] = 8'h3C;
        req[0] = 1'b1;
        wait_gnt(0, "drop_gnt_wait");
        repeat (14) tick();
        req[0] = 1'b0;
        wdata[7:0] = 8'hFF;
        wait_done(0, "drop_done_wait");
        check("drop_bits",   fbits, 9'b001111000);
        check("drop_cs_low", last_lo, 40);

        // Asynchronous reset during bit 4
        rw[3] = 1'b0;
        wdata[31:24] = 8'h5A;
        req[3] = 1'b1;
        wait_gnt(3, "rst_gnt_wait");
        repeat (19) tick();
        d0 = done_cnt[3];
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_cs",   cs,   1'b1);
        check("mid_rst_sclk", sclk, 1'b1);
        check("mid_rst_gnt",  gnt,  4'b0000);
        check("mid_rst_busy", busy, 1'b0);
        req = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (FR + 10) tick();
        check("mid_rst_no_done", done_cnt[3], d0);
        wdata[31:24] = 8'h96;
        req[3] = 1'b1;
        wait_gnt(3, "post_rst_gnt_wait");
        check("post_rst_gnt", gnt, 4'b1000);
        wait_done(3, "post_rst_done_wait");
        req[3] = 1'b0;
        check("post_rst_bits", fbits, 9'b100101100);

`ifdef SPI_ARB_FIXED_PRIO_EN
        // Fixed priority: 2 keeps winning over 3
        grant_log.delete();
        d0 = done_cnt[3];
        rw = '0;
        req = 4'b1100;
        repeat (160) tick();
        check("fp_frames", (grant_log.size() >= 3), 1'b1);
        foreach (grant_log[k]) check("fp_winner", grant_log[k], 2);
        check("fp_no3", done_cnt[3], d0);
        req[2] = 1'b0;
        c = 0;
        while (req != '0 && c < 200) begin
            tick(); c++;
            if (done[3]) req[3] = 1'b0;
        end
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            next_rbyte = 8'($urandom);
            for (int i = 0; i < NR; i++) begin
                if (done[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        req[i] = 1'b0;
                    end else begin
                        rw[i] = 1'($urandom);
                        wdata[i*8 +: 8] = 8'($urandom);
                    end
                end else if (!req[i] && $urandom_range(7, 0) == 0) begin
                    req[i] = 1'b1;
                    rw[i]  = 1'($urandom);
                    wdata[i*8 +: 8] = 8'($urandom);
                end
            end
        end

        // Drain: every pending requester gets served, then drops
        c = 0;
        while (req != '0 && c < 600) begin
            tick(); c++;
            for (int i = 0; i < NR; i++) if (done[i]) req[i] = 1'b0;
        end
        check("drain_req", req, 4'b0000);
        repeat (GAP + 4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
